// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate
// AHB-Lite subordinate backed by a word-organised RAM. Legal transfers get
// WAIT_STATES low-HREADYOUT cycles followed by one OKAY completion cycle.
// Illegal transfers get the standard two-cycle ERROR response.
// Writes commit byte-lane-accurately on the completion edge. Reads sample the
// RAM at the accept edge and merge any write that completes at that same edge.
module ahb_sram_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_LAST = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    logic [2:0]    state, state_nxt;
    logic [3:0]    wait_cnt, wait_cnt_nxt;
    logic [AW-1:0] dp_index;
    logic [3:0]    dp_lanes;
    logic          dp_write;
    logic [31:0]   mem [MEM_WORDS];

    logic          accept, take, legal, in_range, align_ok, commit, forward;
    logic [31:0]   offset, rd_word, rd_merged;
    logic [3:0]    lanes;
    logic [AW-1:0] index;

    // Address-phase decode: acceptance, RAM word index, byte lanes, legality.
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        accept   = HSEL && HREADY && (HTRANS inside {2'b10, 2'b11});
        offset   = HADDR - BASE_ADDR;
        in_range = (HADDR >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
        index    = offset[AW+1:2];
        lanes    = 4'b0000;
        align_ok = 1'b0;
        case (HSIZE)
            3'b000: begin
                lanes    = 4'b0001 << HADDR[1:0];
                align_ok = 1'b1;
            end
            3'b001: begin
                lanes    = HADDR[1] ? 4'b1100 : 4'b0011;
                align_ok = ~HADDR[0];
            end
            3'b010: begin
                lanes    = 4'b1111;
                align_ok = (HADDR[1:0] == 2'b00);
            end
            default: ;
        endcase
        legal = align_ok && in_range;
    end

    // A new address phase can only start when no data phase is stalling the bus.
    always_comb begin
        take    = accept && (state inside {ST_IDLE, ST_LAST, ST_ERR2});
        commit  = (state == ST_LAST) && dp_write;
        forward = commit && (dp_index == index);
    end

    // Read path: the RAM word, with lanes of a same-edge completing write merged in.
    always_comb begin
        rd_word   = mem[index];
        rd_merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (forward && dp_lanes[i]) begin
                rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // Data-phase sequencing: wait countdown, completion, two-cycle error.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE, ST_LAST, ST_ERR2: begin
                wait_cnt_nxt = 4'd0;
                if (!take) begin
                    state_nxt = ST_IDLE;
                end else if (!legal) begin
                    state_nxt = ST_ERR1;
                end else if (WAIT_INIT != 4'd0) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WAIT_INIT;
                end else begin
                    state_nxt = ST_LAST;
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_LAST;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response outputs follow the state directly, so reset clears them at once.
    always_comb begin
        HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
        HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    end

    // Control state, captured data-phase attributes and the read-data register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            dp_index <= '0;
            dp_lanes <= 4'b0000;
            dp_write <= 1'b0;
            HRDATA   <= 32'h0000_0000;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (take && legal) begin
                dp_index <= index;
                dp_lanes <= lanes;
                dp_write <= HWRITE;
                if (!HWRITE) begin
                    HRDATA <= rd_merged;
                end
            end
        end
    end

    // RAM write port: enabled lanes of HWDATA land on the completion edge.
    // NOTE: the RAM array has no reset so it maps onto plain memory; a write
    // interrupted by reset never reaches ST_LAST and so never commits.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_lanes[i]) begin
                    mem[dp_index][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// tb_ahb_sram_subordinate
// Three subordinates (0, 2 and 3 wait states) share one AHB bus. HREADY is the
// AND of their HREADYOUTs. Inputs change on the falling edge and outputs are
// compared there, half a cycle away from the sampling edge.
module tb_ahb_sram_subordinate;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [2:0] SZ_B   = 3'b000;
    localparam logic [2:0] SZ_H   = 3'b001;
    localparam logic [2:0] SZ_W   = 3'b010;
    localparam logic [2:0] SZ_BAD = 3'b011;
    localparam logic [2:0] S0     = 3'b001;
    localparam logic [2:0] S2     = 3'b010;
    localparam logic [2:0] S3     = 3'b100;
    localparam logic [2:0] NONE   = 3'b000;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel0, hsel2, hsel3;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        hready;
    logic        ro0, ro2, ro3, rs0, rs2, rs3;
    logic [31:0] rd0, rd2, rd3;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 HCLK = ~HCLK;

    assign hready = ro0 & ro2 & ro3;

    ahb_sram_subordinate #(.BASE_ADDR(32'h0000_1000), .MEM_WORDS(256), .WAIT_STATES(0)) u0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready),
        .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

    ahb_sram_subordinate #(.BASE_ADDR(32'h0000_1000), .MEM_WORDS(256), .WAIT_STATES(2)) u2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready),
        .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2));

    ahb_sram_subordinate #(.BASE_ADDR(32'h0000_1000), .MEM_WORDS(256), .WAIT_STATES(3)) u3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready),
        .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rr(input string tag, input logic ro, input logic rs,
                            input logic exp_ro, input logic exp_rs);
        check({tag, ".hreadyout"}, 32'(ro), 32'(exp_ro));
        check({tag, ".hresp"}, 32'(rs), 32'(exp_rs));
    endtask

    // One bus cycle: present address-phase and write-data values at the falling edge.
    task automatic step(input logic [2:0] sel, input logic [31:0] addr, input logic [1:0] trans,
                        input logic [2:0] size, input logic write, input logic [31:0] wdata);
        @(negedge HCLK);
        hsel0  = sel[0];
        hsel2  = sel[1];
        hsel3  = sel[2];
        HADDR  = addr;
        HTRANS = trans;
        HSIZE  = size;
        HWRITE = write;
        HWDATA = wdata;
    endtask

    task automatic idle(input logic [31:0] wdata);
        step(NONE, 32'h0, T_IDLE, SZ_W, 1'b0, wdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        hsel0 = 1'b0; hsel2 = 1'b0; hsel3 = 1'b0;
        HADDR = 32'h0; HTRANS = T_IDLE; HSIZE = SZ_W; HWRITE = 1'b0; HWDATA = 32'h0;
        #2;
        check_rr("reset.u0", ro0, rs0, 1'b1, 1'b0);
        check("reset.u0.hrdata", rd0, 32'h0);
        check("reset.u3.hrdata", rd3, 32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        // Zero wait states: clear two words, then byte / halfword / word writes and readback.
        step(S0, 32'h1000, T_NS, SZ_W, 1'b1, 32'h0);
        step(S0, 32'h1004, T_NS, SZ_W, 1'b1, 32'h0000_0000);
        step(S0, 32'h1000, T_NS, SZ_B, 1'b1, 32'h0000_0000);
        step(S0, 32'h1004, T_NS, SZ_H, 1'b1, 32'h0000_0012);
        check_rr("ws0.byte_wr", ro0, rs0, 1'b1, 1'b0);
        step(S0, 32'h1008, T_NS, SZ_W, 1'b1, 32'h0000_3456);
        check_rr("ws0.half_wr", ro0, rs0, 1'b1, 1'b0);
        step(S0, 32'h1000, T_NS, SZ_W, 1'b0, 32'h789a_bcde);
        check_rr("ws0.word_wr", ro0, rs0, 1'b1, 1'b0);
        step(S0, 32'h1004, T_NS, SZ_W, 1'b0, 32'h0);
        check("ws0.rd_1000", rd0, 32'h0000_0012);
        check_rr("ws0.rd_1000", ro0, rs0, 1'b1, 1'b0);
        step(S0, 32'h1008, T_NS, SZ_W, 1'b0, 32'h0);
        check("ws0.rd_1004", rd0, 32'h0000_3456);
        step(S0, 32'h1006, T_NS, SZ_H, 1'b1, 32'h0);
        check("ws0.rd_1008", rd0, 32'h789a_bcde);
        step(S0, 32'h1004, T_NS, SZ_W, 1'b0, 32'hbeef_0000);
        check("ws0.hrdata_hold_on_write", rd0, 32'h789a_bcde);
        idle(32'h0);
        check("ws0.half_upper_lanes", rd0, 32'hbeef_3456);
        idle(32'h0);
        check("ws0.hrdata_hold_idle", rd0, 32'hbeef_3456);

        // Forwarding: word write, byte-lane-2 write, word read, back to back.
        step(S0, 32'h1020, T_NS, SZ_W, 1'b1, 32'h0);
        step(S0, 32'h1022, T_NS, SZ_B, 1'b1, 32'h1122_3344);
        step(S0, 32'h1020, T_NS, SZ_W, 1'b0, 32'h00aa_0000);
        idle(32'h0);
        check("fwd.merged", rd0, 32'h11aa_3344);
        step(S0, 32'h1008, T_NS, SZ_W, 1'b0, 32'h0);
        step(S0, 32'h1020, T_NS, SZ_W, 1'b0, 32'h0);
        check("fwd.other_word", rd0, 32'h789a_bcde);
        idle(32'h0);
        check("fwd.ram_readback", rd0, 32'h11aa_3344);

        // Last RAM word is legal.
        step(S0, 32'h13fc, T_NS, SZ_W, 1'b1, 32'h0);
        idle(32'ha5a5_5a5a);
        step(S0, 32'h13fc, T_NS, SZ_W, 1'b0, 32'h0);
        idle(32'h0);
        check("bound.last_word", rd0, 32'ha5a5_5a5a);
        check_rr("bound.last_word", ro0, rs0, 1'b1, 1'b0);

        // Errors: misaligned word, illegal size, above range, below base.
        step(S0, 32'h1002, T_NS, SZ_W, 1'b1, 32'h0);
        step(S0, 32'h1000, T_NS, SZ_BAD, 1'b1, 32'hffff_ffff);
        check_rr("err.misalign.c1", ro0, rs0, 1'b0, 1'b1);
        step(S0, 32'h1000, T_NS, SZ_BAD, 1'b1, 32'hffff_ffff);
        check_rr("err.misalign.c2", ro0, rs0, 1'b1, 1'b1);
        step(S0, 32'h1400, T_NS, SZ_W, 1'b1, 32'hffff_ffff);
        check_rr("err.size.c1", ro0, rs0, 1'b0, 1'b1);
        step(S0, 32'h1400, T_NS, SZ_W, 1'b1, 32'hffff_ffff);
        check_rr("err.size.c2", ro0, rs0, 1'b1, 1'b1);
        step(S0, 32'h0ffc, T_NS, SZ_W, 1'b1, 32'hffff_ffff);
        check_rr("err.above.c1", ro0, rs0, 1'b0, 1'b1);
        step(S0, 32'h0ffc, T_NS, SZ_W, 1'b1, 32'hffff_ffff);
        check_rr("err.above.c2", ro0, rs0, 1'b1, 1'b1);
        step(S0, 32'h1000, T_NS, SZ_W, 1'b0, 32'hffff_ffff);
        check_rr("err.below.c1", ro0, rs0, 1'b0, 1'b1);
        step(S0, 32'h1000, T_NS, SZ_W, 1'b0, 32'hffff_ffff);
        check_rr("err.below.c2", ro0, rs0, 1'b1, 1'b1);
        idle(32'h0);
        check_rr("err.after", ro0, rs0, 1'b1, 1'b0);
        check("err.ram_unchanged", rd0, 32'h0000_0012);

        // Idle, Busy and unselected transfers do nothing.
        step(S0, 32'h1000, T_IDLE, SZ_W, 1'b1, 32'hffff_ffff);
        step(S0, 32'h1000, T_BUSY, SZ_W, 1'b1, 32'hffff_ffff);
        check_rr("noacc.idle", ro0, rs0, 1'b1, 1'b0);
        step(NONE, 32'h1000, T_NS, SZ_W, 1'b1, 32'hffff_ffff);
        check_rr("noacc.busy", ro0, rs0, 1'b1, 1'b0);
        step(S0, 32'h1000, T_NS, SZ_W, 1'b0, 32'hffff_ffff);
        check_rr("noacc.unsel", ro0, rs0, 1'b1, 1'b0);
        idle(32'h0);
        check("noacc.ram_unchanged", rd0, 32'h0000_0012);

        // Two wait states.
        step(S2, 32'h1010, T_NS, SZ_W, 1'b1, 32'h0);
        step(S2, 32'h1010, T_NS, SZ_W, 1'b0, 32'hdead_beef);
        check_rr("ws2.wr.c1", ro2, rs2, 1'b0, 1'b0);
        step(S2, 32'h1010, T_NS, SZ_W, 1'b0, 32'hdead_beef);
        check_rr("ws2.wr.c2", ro2, rs2, 1'b0, 1'b0);
        step(S2, 32'h1010, T_NS, SZ_W, 1'b0, 32'hdead_beef);
        check_rr("ws2.wr.c3", ro2, rs2, 1'b1, 1'b0);
        check("ws2.hrdata_before_read", rd2, 32'h0);
        idle(32'h0);
        check_rr("ws2.rd.c1", ro2, rs2, 1'b0, 1'b0);
        check("ws2.rd.c1.data", rd2, 32'hdead_beef);
        idle(32'h0);
        check_rr("ws2.rd.c2", ro2, rs2, 1'b0, 1'b0);
        idle(32'h0);
        check_rr("ws2.rd.c3", ro2, rs2, 1'b1, 1'b0);
        check("ws2.rd.c3.data", rd2, 32'hdead_beef);
        idle(32'h0);
        check_rr("ws2.after", ro2, rs2, 1'b1, 1'b0);

        // Three wait states, then reset in the middle of a write.
        step(S3, 32'h1030, T_NS, SZ_W, 1'b1, 32'h0);
        step(S3, 32'h1030, T_NS, SZ_W, 1'b0, 32'hcafe_f00d);
        check_rr("ws3.wr.c1", ro3, rs3, 1'b0, 1'b0);
        step(S3, 32'h1030, T_NS, SZ_W, 1'b0, 32'hcafe_f00d);
        step(S3, 32'h1030, T_NS, SZ_W, 1'b0, 32'hcafe_f00d);
        check_rr("ws3.wr.c3", ro3, rs3, 1'b0, 1'b0);
        step(S3, 32'h1030, T_NS, SZ_W, 1'b0, 32'hcafe_f00d);
        check_rr("ws3.wr.c4", ro3, rs3, 1'b1, 1'b0);
        idle(32'h0);
        check_rr("ws3.rd.c1", ro3, rs3, 1'b0, 1'b0);
        check("ws3.rd.c1.data", rd3, 32'hcafe_f00d);
        idle(32'h0);
        idle(32'h0);
        check_rr("ws3.rd.c3", ro3, rs3, 1'b0, 1'b0);
        step(S3, 32'h1030, T_NS, SZ_W, 1'b1, 32'h0);
        check_rr("ws3.rd.c4", ro3, rs3, 1'b1, 1'b0);
        idle(32'h0bad_f00d);
        check_rr("rst.wr.c1", ro3, rs3, 1'b0, 1'b0);
        idle(32'h0bad_f00d);
        check_rr("rst.wr.c2", ro3, rs3, 1'b0, 1'b0);
        #2;
        HRESETn = 1'b0;
        #1;
        check_rr("rst.immediate", ro3, rs3, 1'b1, 1'b0);
        check("rst.immediate.hrdata", rd3, 32'h0);
        idle(32'h0bad_f00d);
        idle(32'h0bad_f00d);
        HRESETn = 1'b1;
        step(S3, 32'h1030, T_NS, SZ_W, 1'b0, 32'h0);
        check_rr("rst.after", ro3, rs3, 1'b1, 1'b0);
        idle(32'h0);
        check_rr("rst.rd.c1", ro3, rs3, 1'b0, 1'b0);
        idle(32'h0);
        idle(32'h0);
        idle(32'h0);
        check_rr("rst.rd.c4", ro3, rs3, 1'b1, 1'b0);
        check("rst.write_discarded", rd3, 32'hcafe_f00d);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
